mips_calc_processor: RTL and testbench

- Switch-driven 4-digit decimal calculator with a 16-word data memory, for DE-class FPGA boards.
- A single active-low enter key steps a control FSM through four operations: save word, read word, enter opcode, execute opcode.
- Results go to the memory or to four active-low 7-segment digits; LEDs show FSM state and error status.

---
 rtl/mips_calc_pkg.sv | 48 ++++
 rtl/bcd_seg7.sv | 26 ++
 rtl/mips_calc_processor.sv | 134 +++++++++++++
 tb/tb_mips_calc_processor.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mips_calc_pkg.sv
// Shared types and constants for the switch-driven MIPS-style calculator.
// Holds the FSM encoding, ALU opcodes, display constants and the memory default image.
package mips_calc_pkg;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 4;
  localparam int MEM_WORDS = 1 << ADDR_W;
  localparam int MAX_VAL   = 9999;
  localparam int DISP_W    = 14;

  typedef enum logic [2:0] {
    IDLE, SAVE_ADDR, SAVE_DATA, READ_ADDR, READ_DATA, OP_IN1, OP_IN2, OP_EXEC
  } state_t;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  typedef enum logic [1:0] {DISP_BLANK, DISP_NUM, DISP_DASH} disp_mode_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef logic [MEM_WORDS-1:0][DATA_W-1:0] mem_t;

  function automatic mem_t mem_default();
    mem_t m;
    m    = '0;
    m[1] = DATA_W'(12345);
    return m;
  endfunction

  localparam mem_t MEM_DEFAULT = mem_default();

  // Active-low gfedcba decode of one BCD digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/bcd_seg7.sv
// Binary-to-4-digit 7-segment converter: double-dabble then per-digit decode.
// seg[3] is the thousands digit, seg[0] the units digit.
module bcd_seg7
  import mips_calc_pkg::*;
(
  input  logic [DISP_W-1:0] bin,
  output logic [3:0][6:0]   seg
);
  logic [15:0] bcd;

  always_comb begin
    logic [DISP_W+15:0] sh;
    sh = {16'b0, bin};
    for (int i = 0; i < DISP_W; i++) begin
      for (int d = 0; d < 4; d++)
        if (sh[DISP_W+4*d +: 4] >= 4'd5)
          sh[DISP_W+4*d +: 4] = sh[DISP_W+4*d +: 4] + 4'd3;
      sh = sh << 1;
    end
    bcd = sh[DISP_W +: 16];
  end

  for (genvar g = 0; g < 4; g++) begin : g_dig
    assign seg[g] = seg7(bcd[4*g +: 4]);
  end
endmodule

// File: rtl/mips_calc_processor.sv
// Enter-key stepped calculator: save/read words of a 16-word memory and run
// add/sub/mul/div on them, sending results to memory or the 4-digit display.
module mips_calc_processor
  import mips_calc_pkg::*;
(
  input  logic       clk_50M,
  input  logic       rst_bar,
  input  logic       mem_rst_bar,
  input  logic       enter_bar,
  input  logic [9:0] sw,
  output logic [7:0] LEDG,
  output logic [6:0] segment_1000,
  output logic [6:0] segment_100,
  output logic [6:0] segment_10,
  output logic [6:0] segment_1
);
  state_t             state;
  mem_t               mem = MEM_DEFAULT;
  logic [1:0]         enter_q;
  logic               enter_p;
  logic [ADDR_W-1:0]  addr, sr1, sr2;
  op_t                op;
  logic               imm, out_sel, err;
  logic [DISP_W-1:0]  disp_val;
  disp_mode_t         disp_mode;

  logic [DATA_W-1:0]  op_a, op_b;
  logic [31:0]        res;
  logic               exe_err;
  logic [3:0][6:0]    seg_num, seg_out;

  assign enter_p = enter_q[1] & ~enter_q[0];

  always_comb begin
    op_a    = mem[sr1];
    op_b    = imm ? DATA_W'(sr2) : mem[sr2];
    res     = '0;
    exe_err = 1'b0;
    case (op)
      OP_ADD: res = 32'(op_a) + 32'(op_b);
      OP_SUB: begin
        res     = 32'(op_a) - 32'(op_b);
        exe_err = op_a < op_b;
      end
      OP_MUL: res = 32'(op_a) * 32'(op_b);
      OP_DIV: begin
        exe_err = (op_b == '0);
        res     = exe_err ? '0 : 32'(op_a / op_b);
      end
      default: res = '0;
    endcase
    if (res > 32'(MAX_VAL)) exe_err = 1'b1;
  end

  always_ff @(posedge clk_50M) begin
    enter_q <= {enter_q[0], enter_bar};
    if (!mem_rst_bar) mem <= MEM_DEFAULT;
    // Either reset wins over a coincident enter pulse and aborts any pending write.
    if (!rst_bar || !mem_rst_bar) begin
      state     <= IDLE;
      addr      <= '0;
      sr1       <= '0;
      sr2       <= '0;
      op        <= OP_ADD;
      imm       <= 1'b0;
      out_sel   <= 1'b0;
      err       <= 1'b0;
      disp_val  <= '0;
      disp_mode <= DISP_BLANK;
    end else if (enter_p) begin
      case (state)
        IDLE: begin
          if (sw == 10'd2)      begin state <= SAVE_ADDR; err <= 1'b0; end
          else if (sw == 10'd3) begin state <= READ_ADDR; err <= 1'b0; end
          else if (sw == 10'd4) begin state <= OP_IN1;    err <= 1'b0; end
        end
        SAVE_ADDR: begin addr <= sw[3:0]; state <= SAVE_DATA; end
        SAVE_DATA: begin mem[addr] <= DATA_W'(sw); state <= IDLE; end
        READ_ADDR: begin addr <= sw[3:0]; state <= READ_DATA; end
        READ_DATA: begin
          disp_val <= mem[addr][DISP_W-1:0];
          if (mem[addr] > DATA_W'(MAX_VAL)) begin
            disp_mode <= DISP_DASH;
            err       <= 1'b1;
          end else begin
            disp_mode <= DISP_NUM;
          end
          state <= IDLE;
        end
        OP_IN1: begin
          sr1   <= sw[9:6];
          sr2   <= sw[5:2];
          op    <= op_t'(sw[1:0]);
          state <= OP_IN2;
        end
        OP_IN2: begin
          imm     <= sw[5];
          addr    <= sw[4:1];
          out_sel <= sw[0];
          state   <= OP_EXEC;
        end
        OP_EXEC: begin
          if (exe_err) begin
            err       <= 1'b1;
            disp_mode <= DISP_DASH;
          end else if (out_sel) begin
            disp_val  <= res[DISP_W-1:0];
            disp_mode <= DISP_NUM;
          end else begin
            mem[addr] <= res[DATA_W-1:0];
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  bcd_seg7 u_bcd (
    .bin (disp_val),
    .seg (seg_num)
  );

  always_comb begin
    case (disp_mode)
      DISP_NUM:  seg_out = seg_num;
      DISP_DASH: seg_out = {4{SEG_DASH}};
      default:   seg_out = {4{SEG_BLANK}};
    endcase
  end

  assign {segment_1000, segment_100, segment_10, segment_1} = seg_out;
  assign LEDG = {err, addr, state};
endmodule

// File: tb/tb_mips_calc_processor.sv
// Directed bench for mips_calc_processor: key presses through save/read/opcode
// flows with hand-computed display and LED expectations.
module tb_mips_calc_processor;
  logic       clk_50M = 1'b0;
  logic       rst_bar, mem_rst_bar, enter_bar;
  logic [9:0] sw;
  logic [7:0] LEDG;
  logic [6:0] segment_1000, segment_100, segment_10, segment_1;

  int checks = 0;
  int errors = 0;

  logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [27:0] disp_dash  = {4{7'h3F}};
  logic [27:0] disp_blank = {4{7'h7F}};

  always #10 clk_50M = ~clk_50M;

  mips_calc_processor dut (
    .clk_50M      (clk_50M),
    .rst_bar      (rst_bar),
    .mem_rst_bar  (mem_rst_bar),
    .enter_bar    (enter_bar),
    .sw           (sw),
    .LEDG         (LEDG),
    .segment_1000 (segment_1000),
    .segment_100  (segment_100),
    .segment_10   (segment_10),
    .segment_1    (segment_1)
  );

  function automatic logic [27:0] num_disp(input int n);
    return {segtab[(n / 1000) % 10], segtab[(n / 100) % 10],
            segtab[(n / 10) % 10], segtab[n % 10]};
  endfunction

  function automatic logic [27:0] disp();
    return {segment_1000, segment_100, segment_10, segment_1};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [9:0] v);
    @(negedge clk_50M);
    sw = v;
    enter_bar = 1'b0;
    repeat (3) @(negedge clk_50M);
    enter_bar = 1'b1;
    repeat (3) @(negedge clk_50M);
  endtask

  task automatic save(input logic [3:0] a, input logic [9:0] v);
    press(10'd2); press({6'd0, a}); press(v);
  endtask

  task automatic read(input logic [3:0] a);
    press(10'd3); press({6'd0, a}); press(10'd0);
  endtask

  task automatic do_op(input logic [3:0] s1, input logic [3:0] s2, input logic [1:0] opc,
                       input logic im, input logic [3:0] dr, input logic out);
    press(10'd4); press({s1, s2, opc}); press({4'd0, im, dr, out}); press(10'd0);
  endtask

  initial begin
    rst_bar = 1'b0; mem_rst_bar = 1'b0; enter_bar = 1'b1; sw = '0;
    repeat (3) @(negedge clk_50M);
    rst_bar = 1'b1; mem_rst_bar = 1'b1;
    @(negedge clk_50M);
    check("reset_ledg", LEDG, 8'h00);
    check("reset_disp", disp(), disp_blank);

    // Power-up image: mem[1]=12345 is not displayable.
    press(10'd3);
    check("read_addr_state", LEDG, 8'h03);
    press(10'd1);
    check("read_data_state", LEDG, 8'h0C);
    press(10'd0);
    check("read1_default_disp", disp(), disp_dash);
    check("read1_default_led", LEDG, 8'h88);

    save(4'd1, 10'd777);
    read(4'd1);
    check("read1_777_disp", disp(), num_disp(777));
    check("read1_777_led", LEDG, 8'h08);

    save(4'd2, 10'd100);
    save(4'd3, 10'd30);
    for (int k = 0; k < 4; k++) do_op(4'd2, 4'd3, 2'(k), 1'b0, 4'(4 + k), 1'b0);
    read(4'd4); check("mem4_add", disp(), num_disp(130));
    read(4'd5); check("mem5_sub", disp(), num_disp(70));
    read(4'd6); check("mem6_mul", disp(), num_disp(3000));
    read(4'd7); check("mem7_div", disp(), num_disp(3));

    do_op(4'd2, 4'd3, 2'd0, 1'b0, 4'd8, 1'b1); check("disp_add", disp(), num_disp(130));
    do_op(4'd2, 4'd3, 2'd1, 1'b0, 4'd8, 1'b1); check("disp_sub", disp(), num_disp(70));
    do_op(4'd2, 4'd3, 2'd2, 1'b0, 4'd8, 1'b1); check("disp_mul", disp(), num_disp(3000));
    do_op(4'd2, 4'd3, 2'd3, 1'b0, 4'd8, 1'b1); check("disp_div", disp(), num_disp(3));
    check("disp_div_led", LEDG[7], 1'b0);
    read(4'd8); check("mem8_untouched", disp(), num_disp(0));

    do_op(4'd3, 4'd1, 2'd1, 1'b0, 4'd9, 1'b0);
    check("err_sub_disp", disp(), disp_dash);
    check("err_sub_led", LEDG, {1'b1, 4'd9, 3'd0});
    do_op(4'd1, 4'd1, 2'd2, 1'b0, 4'd10, 1'b0);
    check("err_mul_disp", disp(), disp_dash);
    check("err_mul_led", LEDG, {1'b1, 4'd10, 3'd0});
    do_op(4'd2, 4'd0, 2'd3, 1'b0, 4'd11, 1'b0);
    check("err_div0_disp", disp(), disp_dash);
    check("err_div0_led", LEDG, {1'b1, 4'd11, 3'd0});
    press(10'd3);
    check("err_clear_on_enter", LEDG[7], 1'b0);
    press(10'd9); press(10'd0);
    check("err_sub_nowrite", disp(), num_disp(0));
    read(4'd10); check("err_mul_nowrite", disp(), num_disp(0));
    read(4'd11); check("err_div_nowrite", disp(), num_disp(0));

    do_op(4'd2, 4'd3, 2'd0, 1'b1, 4'd0, 1'b1); check("addi", disp(), num_disp(103));
    do_op(4'd2, 4'd3, 2'd1, 1'b1, 4'd0, 1'b1); check("subi", disp(), num_disp(97));
    do_op(4'd2, 4'd3, 2'd2, 1'b1, 4'd0, 1'b1); check("muli", disp(), num_disp(300));
    do_op(4'd2, 4'd3, 2'd3, 1'b1, 4'd0, 1'b1); check("divi", disp(), num_disp(33));

    // Abort an opcode mid-entry with rst_bar.
    press(10'd4); press({4'd2, 4'd3, 2'd0});
    check("op_in2_state", LEDG[2:0], 3'd6);
    @(negedge clk_50M); rst_bar = 1'b0;
    repeat (2) @(negedge clk_50M); rst_bar = 1'b1;
    @(negedge clk_50M);
    check("rst_ledg", LEDG, 8'h00);
    check("rst_disp", disp(), disp_blank);
    press(10'd0);
    check("rst_enter_idle", LEDG[2:0], 3'd0);
    read(4'd12); check("rst_no_write", disp(), num_disp(0));
    read(4'd2);  check("rst_mem_kept", disp(), num_disp(100));
    read(4'd4);  check("rst_mem4_kept", disp(), num_disp(130));

    @(negedge clk_50M); mem_rst_bar = 1'b0;
    repeat (2) @(negedge clk_50M); mem_rst_bar = 1'b1;
    @(negedge clk_50M);
    check("memrst_ledg", LEDG, 8'h00);
    check("memrst_disp", disp(), disp_blank);
    read(4'd2); check("memrst_mem2", disp(), num_disp(0));
    read(4'd4); check("memrst_mem4", disp(), num_disp(0));
    read(4'd1);
    check("memrst_mem1_disp", disp(), disp_dash);
    check("memrst_mem1_led", LEDG[7], 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
